// File: rtl/pa_decode.sv
// pa_decode: decode stage for a single-opcode (R-type add) pipeline.
// Holds the 32-entry register file with writeback bypass, tracks pending
// destinations in a scoreboard, stalls fetch on RAW hazards and registers
// the decoded operands for the next stage.
module pa_decode #(
    parameter logic [5:0] OPC_R     = 6'b000000,
    parameter logic [5:0] FUNCT_ADD = 6'b100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] counter,
    input  logic        in_valid,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_rs_val,
    output logic [31:0] out_rt_val,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    // Instruction fields
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];

    logic [31:0] regs [32];
    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic        legal;
    logic        wb_hit_rs;
    logic        wb_hit_rt;
    logic        issue;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    assign legal     = (opcode == OPC_R) && (funct == FUNCT_ADD) && (shamt == 5'd0);
    // A same-cycle writeback to a nonzero address resolves the hazard and feeds the operand.
    assign wb_hit_rs = wb_en && (wb_addr == rs) && (rs != 5'd0);
    assign wb_hit_rt = wb_en && (wb_addr == rt) && (rt != 5'd0);

    // Hazard detection; illegal instructions never wait because they read nothing.
    always_comb begin
        stall = 1'b0;
        if (in_valid && legal) begin
            stall = (pending[rs] && (rs != 5'd0) && !wb_hit_rs) ||
                    (pending[rt] && (rt != 5'd0) && !wb_hit_rt);
        end
    end

    assign issue = in_valid && !stall;

    // Operand read with r0 forced to zero and writeback bypass.
    always_comb begin
        // NOTE: always_comb uses blocking assignments, with a default first so no latch is inferred.
        rs_val = regs[rs];
        rt_val = regs[rt];
        if (rs == 5'd0)  rs_val = 32'd0;
        else if (wb_hit_rs) rs_val = wb_data;
        if (rt == 5'd0)  rt_val = 32'd0;
        else if (wb_hit_rt) rt_val = wb_data;
    end

    // Scoreboard update: writeback clears, issue of a legal rd sets, and set is applied last so it wins.
    always_comb begin
        pending_nxt = pending;
        if (wb_en) pending_nxt[wb_addr] = 1'b0;
        if (issue && legal && (rd != 5'd0)) pending_nxt[rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Register file: reset to its own index, written by the final stage.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this memory is deliberately reset (each entry to its index), so it maps to flops, not RAM.
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'(i);
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            // NOTE: sequential state uses non-blocking assignments only.
            regs[wb_addr] <= wb_data;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= 32'd0;
        else        pending <= pending_nxt;
    end

    // Decode output register; payload holds during bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_illegal <= 1'b0;
            out_pc      <= 32'd0;
            out_rs_val  <= 32'd0;
            out_rt_val  <= 32'd0;
            out_rd      <= 5'd0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_pc    <= counter;
            if (legal) begin
                out_illegal <= 1'b0;
                out_rs_val  <= rs_val;
                out_rt_val  <= rt_val;
                out_rd      <= rd;
            end else begin
                out_illegal <= 1'b1;
                out_rs_val  <= 32'd0;
                out_rt_val  <= 32'd0;
                out_rd      <= 5'd0;
            end
        end else begin
            out_valid   <= 1'b0;
            out_illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pa_decode.sv
// Directed testbench for pa_decode with hand-computed expectations.
module tb_pa_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] counter;
    logic        in_valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_rs_val;
    logic [31:0] out_rt_val;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    pa_decode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .counter    (counter),
        .in_valid   (in_valid),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_rs_val (out_rs_val),
        .out_rt_val (out_rt_val),
        .out_rd     (out_rd),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; instr = '0; counter = '0; in_valid = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_rs_val", out_rs_val, 32'd0);
        check("rst_rt_val", out_rt_val, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_pending", dut.pending, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        // First issue: r2 + r13 -> r9
        instr = r_add(5'd2, 5'd13, 5'd9); counter = 32'd0; in_valid = 1'b1;
        #1 check("a_stall", 32'(stall), 32'd0);
        step();
        check("a_valid", 32'(out_valid), 32'd1);
        check("a_rs", out_rs_val, 32'd2);
        check("a_rt", out_rt_val, 32'd13);
        check("a_rd", 32'(out_rd), 32'd9);
        check("a_pc", out_pc, 32'd0);
        check("a_illegal", 32'(out_illegal), 32'd0);
        check("a_pend9", 32'(dut.pending[9]), 32'd1);

        // RAW on r9: stall until writeback of 15 to r9
        instr = r_add(5'd3, 5'd9, 5'd13); counter = 32'd1;
        #1 check("b_stall0", 32'(stall), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("b_bubble_valid", 32'(out_valid), 32'd0);
            check("b_bubble_rd_hold", 32'(out_rd), 32'd9);
            check("b_stall", 32'(stall), 32'd1);
        end
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'd15;
        #1 check("b_stall_wb", 32'(stall), 32'd0);
        step();
        wb_en = 1'b0;
        check("b_valid", 32'(out_valid), 32'd1);
        check("b_rs", out_rs_val, 32'd3);
        check("b_rt_bypass", out_rt_val, 32'd15);
        check("b_rd", 32'(out_rd), 32'd13);
        check("b_pc", out_pc, 32'd1);
        check("b_pending", dut.pending, 32'h0000_2000);

        // rs == rt == rd == 16, then repeat stalls on itself
        instr = r_add(5'd16, 5'd16, 5'd16); counter = 32'd2;
        #1 check("c_stall0", 32'(stall), 32'd0);
        step();
        check("c_valid", 32'(out_valid), 32'd1);
        check("c_rs", out_rs_val, 32'd16);
        check("c_rt", out_rt_val, 32'd16);
        check("c_rd", 32'(out_rd), 32'd16);
        check("c_pend16", 32'(dut.pending[16]), 32'd1);
        check("c_repeat_stall", 32'(stall), 32'd1);
        step();
        check("c_repeat_bubble", 32'(out_valid), 32'd0);

        // Illegal opcode reading a pending register: no stall, zeroed outputs
        instr = {6'b100011, 5'd16, 5'd13, 5'd7, 5'd0, 6'b100000}; counter = 32'd3;
        #1 check("d_stall", 32'(stall), 32'd0);
        step();
        check("d_valid", 32'(out_valid), 32'd1);
        check("d_illegal", 32'(out_illegal), 32'd1);
        check("d_rd", 32'(out_rd), 32'd0);
        check("d_rs", out_rs_val, 32'd0);
        check("d_rt", out_rt_val, 32'd0);
        check("d_pending", dut.pending, 32'h0001_2000);

        // Illegal funct (sub)
        instr = {6'b000000, 5'd13, 5'd16, 5'd5, 5'd0, 6'b100010}; counter = 32'd4;
        #1 check("e_stall", 32'(stall), 32'd0);
        step();
        check("e_illegal", 32'(out_illegal), 32'd1);
        check("e_rd", 32'(out_rd), 32'd0);
        check("e_pending", dut.pending, 32'h0001_2000);

        // Write to r0 is ignored and not bypassed
        instr = r_add(5'd0, 5'd1, 5'd2); counter = 32'd5;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        step();
        wb_en = 1'b0;
        check("f_rs_r0", out_rs_val, 32'd0);
        check("f_rt", out_rt_val, 32'd1);
        check("f_rd", 32'(out_rd), 32'd2);
        check("f_pc", out_pc, 32'd5);

        // Register file retained the earlier writeback of r9
        instr = r_add(5'd9, 5'd0, 5'd0); counter = 32'd6;
        step();
        check("g_r9", out_rs_val, 32'd15);
        check("g_rt_r0", out_rt_val, 32'd0);

        // Reset while stalled on r16 with a writeback in flight
        instr = r_add(5'd16, 5'd1, 5'd3); counter = 32'd7;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'd77;
        #1 check("h_stall_pre", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("h_stall_rst", 32'(stall), 32'd0);
        check("h_valid_rst", 32'(out_valid), 32'd0);
        check("h_pending_rst", dut.pending, 32'd0);
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        rst_n = 1'b1;
        instr = r_add(5'd9, 5'd10, 5'd0); counter = 32'd8;
        step();
        check("h_valid_first", 32'(out_valid), 32'd1);
        check("h_r9_reset", out_rs_val, 32'd9);
        check("h_r10", out_rt_val, 32'd10);

        in_valid = 1'b0;
        step();
        check("i_idle_bubble", 32'(out_valid), 32'd0);
        check("i_pc_hold", out_pc, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pa_decode.md
PA_DECODE -- requirements
Module: pa_decode

Parameters
REQ-001 OPC_R, default 6'b000000, opcode accepted as R-type.
REQ-002 FUNCT_ADD, default 6'b100000, funct accepted as add.

Interface
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 instr  input  32  instruction word from fetch: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct.
REQ-006 counter  input  32  instruction-memory index of instr.
REQ-007 in_valid  input  1  instr/counter valid this cycle.
REQ-008 wb_en  input  1  writeback strobe from the final stage.
REQ-009 wb_addr  input  5  writeback destination register.
REQ-010 wb_data  input  32  writeback value.
REQ-011 stall  output  1  combinational; upstream SHALL hold instr/counter while high.
REQ-012 out_valid  output  1  registered; decoded instruction present.
REQ-013 out_pc  output  32  registered copy of counter.
REQ-014 out_rs_val  output  32  registered rs operand.
REQ-015 out_rt_val  output  32  registered rt operand.
REQ-016 out_rd  output  5  registered destination.
REQ-017 out_illegal  output  1  registered; instruction not OPC_R/FUNCT_ADD with shamt 0.

Function
REQ-018 Register file: 32 x 32-bit; r0 reads 0 always; writes to r0 ignored.
REQ-019 Writeback: when wb_en=1 and wb_addr!=0, regfile[wb_addr] <= wb_data at the clock edge.
REQ-020 Read bypass: if wb_en=1 and wb_addr==rs (or rt), nonzero, the operand takes wb_data in that same cycle.
REQ-021 Scoreboard: 32-bit pending vector; bit set when a legal instruction with rd!=0 issues; bit cleared when wb_en writes that address.
REQ-022 Same-cycle set and clear of one address: set wins.
REQ-023 stall = in_valid & ((pending[rs] & rs!=0 & !(wb_en & wb_addr==rs)) | (pending[rt] & rt!=0 & !(wb_en & wb_addr==rt))).
REQ-024 Issue: in_valid=1 and stall=0 at an edge; latency 1 cycle (outputs valid after that edge).
REQ-025 On issue: out_valid=1, out_pc=counter, out_rs_val/out_rt_val per REQ-018..020, out_rd=rd, out_illegal=0.
REQ-026 Illegal issue: out_valid=1, out_illegal=1, out_rd=0, operand outputs 0, scoreboard unchanged, no stall check applied.
REQ-027 No issue (in_valid=0 or stall=1): out_valid=0 next cycle (bubble); out_pc/out_rd/operands hold previous values.
REQ-028 rs==rt: single pending check; both operands identical.
REQ-029 Instruction with rd equal to its own rs/rt: operands read old value, then rd marked pending.

Reset
REQ-030 rst_n=0 asynchronously: regfile[i]=i for i=0..31, pending=0, out_valid=0, out_illegal=0, out_pc=0, out_rs_val=0, out_rt_val=0, out_rd=0.
REQ-031 Reset mid-stall: stall deasserts immediately (pending cleared); in-flight writeback in that cycle is discarded.
REQ-032 First issue possible at the first rising edge after rst_n rises.

Verification
REQ-033 After reset, instr=000000_00010_01101_01001_00000_100000, counter=0, in_valid=1 -> next cycle out_valid=1, out_rs_val=2, out_rt_val=13, out_rd=9, out_pc=0, pending[9]=1.
REQ-034 Then instr=000000_00011_01001_01101_00000_100000 (reads r9) with no writeback -> stall=1, out_valid=0 each cycle; wb_en=1, wb_addr=9, wb_data=15 -> stall=0 that cycle, next cycle out_rs_val=3, out_rt_val=15, out_rd=13.
REQ-035 instr=000000_10000_10000_10000_00000_100000 -> out_rs_val=out_rt_val=16, out_rd=16, pending[16]=1; repeat immediately -> stall=1.
REQ-036 instr opcode 6'b100011 or funct 6'b100010 -> out_valid=1, out_illegal=1, out_rd=0, pending unchanged, stall never asserted.
REQ-037 wb_en=1, wb_addr=0, wb_data=32'hFFFFFFFF, then instr reading rs=0 -> out_rs_val=0.
REQ-038 Assert rst_n=0 while stall=1 -> stall, out_valid, pending all 0 immediately; regfile reads r9=9 after release.
